// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// registered data/data_valid/framing_error/busy outputs.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        rx_meta;
    logic        rx_s;

    // Synchronizer resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_CNT) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data       <= shift;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized
// frames compared against a frame-level reference model.
module tb_uart_receiver;

    localparam int unsigned C = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk           (clk),
        .reset         (reset),
        .RxD           (RxD),
        .data          (data),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] dv_q[$];
    int         dv_t[$];
    int         fe_cnt    = 0;
    int         both_cnt  = 0;
    int         wide_cnt  = 0;
    logic       dv_prev   = 1'b0;
    logic       fe_prev   = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;
    int         exp_fe   = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_q.push_back(data);
            dv_t.push_back(cyc);
        end
        if (framing_error) fe_cnt++;
        if (data_valid && framing_error) both_cnt++;
        if ((data_valid && dv_prev) || (framing_error && fe_prev)) wide_cnt++;
        dv_prev = data_valid;
        fe_prev = framing_error;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Reference: a frame with a high stop bit delivers its byte; a low stop bit is one error.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_q.push_back(b);
            exp_data = b;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_dv_count"}, dv_q.size(), exp_q.size());
        check({tag, "_fe_count"}, fe_cnt, exp_fe);
        check({tag, "_data"}, data, exp_data);
    endtask

    // Caller must be at a falling clock edge; returns at a falling edge at end of stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, output int start_cyc);
        RxD = 1'b0;
        start_cyc = cyc;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (C) @(negedge clk);
        end
        RxD = stop_ok;
        repeat (C) @(negedge clk);
    endtask

    initial begin
        int t0, t1, lat, gap, n;
        logic [7:0] b;
        logic [7:0] pb;
        logic ok;

        reset = 1'b1;
        RxD   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_dv", data_valid, 1'b0);
        check("rst_fe", framing_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        // Single frame 0xA5 with latency measurement
        send_frame(8'hA5, 1'b1, t0);
        model_frame(8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        check_state("a5");
        if (dv_q.size() > 0) begin
            lat = dv_t[dv_q.size() - 1] - t0;
            check("a5_latency", (lat >= 149 && lat <= 155) ? 152 : lat, 152);
        end
        check("a5_busy_after", busy, 1'b0);

        // Back-to-back 0x00, 0xFF with no idle gap
        send_frame(8'h00, 1'b1, t0);
        model_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1, t1);
        model_frame(8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        check_state("b2b");
        n = dv_q.size();
        if (n >= 2) begin
            gap = dv_t[n - 1] - dv_t[n - 2];
            check("b2b_spacing", (gap >= 159 && gap <= 161) ? 160 : gap, 160);
            check("b2b_first", dv_q[n - 2], 8'h00);
        end

        // False start: low for 4 cycles
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        RxD = 1'b1;
        repeat (30) @(negedge clk);
        check_state("false_start");
        check("false_start_busy", busy, 1'b0);

        // Framing error followed by a held-low line, then a good frame
        send_frame(8'h3C, 1'b0, t0);
        model_frame(8'h3C, 1'b0);
        repeat (200) @(negedge clk);
        check("break_busy_mid", busy, 1'b1);
        repeat (200) @(negedge clk);
        check_state("break_hold");
        check("break_busy_end", busy, 1'b1);
        RxD = 1'b1;
        repeat (5) @(negedge clk);
        check("break_busy_release", busy, 1'b0);
        send_frame(8'h5A, 1'b1, t0);
        model_frame(8'h5A, 1'b1);
        repeat (5) @(negedge clk);
        check_state("after_break");

        // Reset in the middle of bit 4
        pb = 8'h69;
        RxD = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RxD = pb[i];
            repeat (C) @(negedge clk);
        end
        RxD = pb[4];
        repeat (C / 2) @(negedge clk);
        reset = 1'b1;
        exp_data = 8'h00;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_dv", data_valid, 1'b0);
        check("midrst_fe", framing_error, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_state("midrst_quiet");
        send_frame(8'hC3, 1'b1, t0);
        model_frame(8'hC3, 1'b1);
        repeat (5) @(negedge clk);
        check_state("midrst_c3");

        // Randomized frames, mixed good/bad stop bits and gaps
        for (int k = 0; k < 24; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, t0);
            model_frame(b, ok);
            if (!ok) begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
                RxD = 1'b1;
                repeat ($urandom_range(1, 10)) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 10)) @(negedge clk);
            end
        end
        RxD = 1'b1;
        repeat (40) @(negedge clk);
        check_state("rand");
        check("rand_busy_idle", busy, 1'b0);
        if (dv_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++)
                check($sformatf("byte_%0d", i), dv_q[i], exp_q[i]);
        end
        check("dv_fe_exclusive", both_cnt, 0);
        check("pulse_width", wide_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
